// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the stream_demux_1_n slice.
//   clog2      - ceiling log2 helper (minimum result 1) used to size selects
//   sel_t      - slot index type for the default 4-channel build
//   RESET_DATA - value held by every slot after reset
package demux_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int N_OUT_DEFAULT = 4;
    localparam int SEL_W_DEFAULT = clog2(N_OUT_DEFAULT);

    typedef logic [SEL_W_DEFAULT-1:0] sel_t;

    localparam logic RESET_DATA = 1'b0;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single demux output channel.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - write d this edge (takes priority over drain)
//   d          - incoming word
//   ready      - consumer takes the held word this cycle
//   valid      - a word is held
//   q          - held word; retains its last value after drain
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= {DATA_W{RESET_DATA}};
        end else begin
            // a reload in the same cycle as a drain keeps the slot full
            valid <= load | (valid & ~ready);
            if (load) q <= d;
        end
    end

endmodule

// File: rtl/stream_demux_1_n.sv
// stream_demux_1_n: registered 1:N valid/ready demultiplexer.
// Each channel has its own one-entry slot, so one stalled sink does not block
// traffic to the others. Out-of-range selects are accepted, dropped and
// flagged with a one-cycle sel_err pulse.
// Optional feature: define DEMUX_AUTO_SEQ_EN to add the auto_en port and a
// round-robin pointer that replaces in_sel while auto_en=1.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - producer handshake (in_ready is combinational)
//   in_data, in_sel     - word and destination channel
//   auto_en             - auto-sequence mode (DEMUX_AUTO_SEQ_EN only)
//   out_valid/out_ready - per-channel consumer handshake
//   out_data            - channel i at [i*DATA_W +: DATA_W]
//   sel_err             - accepted word had an out-of-range select
module stream_demux_1_n
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
`ifdef DEMUX_AUTO_SEQ_EN
    input  logic                    auto_en,
`endif
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    sel_err
);

    localparam logic [SEL_W:0] N_OUT_EXT = (SEL_W+1)'(N_OUT);

    logic [SEL_W-1:0] dest;
    logic             in_range;
    logic             accept;
    logic [N_OUT-1:0] load;

`ifdef DEMUX_AUTO_SEQ_EN
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_OUT - 1);

    logic [SEL_W-1:0] ptr;

    assign dest = auto_en ? ptr : in_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && auto_en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + SEL_W'(1);
        end
    end
`else
    assign dest = in_sel;
`endif

    assign in_range = ({1'b0, dest} < N_OUT_EXT);
    assign accept   = in_valid & in_ready;

    // out-of-range destinations are always ready so the word can be dropped
    always_comb begin
        in_ready = 1'b1;
        load     = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (dest == SEL_W'(i)) begin
                in_ready = ~out_valid[i] | out_ready[i];
                load[i]  = accept;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= accept & ~in_range;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk  (clk),
            .rst_n(rst_n),
            .load (load[g]),
            .d    (in_data),
            .ready(out_ready[g]),
            .valid(out_valid[g]),
            .q    (out_data[g*DATA_W +: DATA_W])
        );
    end

endmodule
